// File: rtl/rcg_opcg_pkg.sv
// Shared types and constants for the OPCG capture scheduler.
package rcg_opcg_pkg;

  localparam int unsigned NUM_DOM   = 4;
  localparam int unsigned DOM_IDX_W = $clog2(NUM_DOM);
  localparam int unsigned GAP_W     = 4;
  localparam int unsigned TMO_W     = 8;

  localparam logic [TMO_W-1:0] TIMEOUT_MAX = 8'd255;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_WAIT,
    ST_GAP,
    ST_DONE
  } state_e;

endpackage

// File: rtl/rcg_opcg_pri_enc.sv
// Lowest-set-bit priority encoder used to pick the next domain to capture.
module rcg_opcg_pri_enc
  import rcg_opcg_pkg::*;
(
  input  logic [NUM_DOM-1:0]   req,
  output logic [DOM_IDX_W-1:0] idx_c,
  output logic                 vld_c
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx_c = '0;
    vld_c = 1'b0;
    for (int i = NUM_DOM - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx_c = DOM_IDX_W'(i);
        vld_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rcg_opcg_sched.sv
// Sequences OPCG capture triggers across clock domains, one domain at a time.
// Optional WAIT timeout with sticky err: define RCG_OPCG_SCHED_TIMEOUT_EN.
module rcg_opcg_sched
  import rcg_opcg_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 grst_n,
  input  logic                 scan_mode,
  input  logic                 opcg_mode,
  input  logic                 start,
  input  logic [NUM_DOM-1:0]   dom_mask,
  input  logic [GAP_W-1:0]     gap_cfg,
  input  logic [NUM_DOM-1:0]   dom_done,
  output logic [NUM_DOM-1:0]   dom_trig,
  output logic [DOM_IDX_W-1:0] cur_dom,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  state_e               state;
  logic [NUM_DOM-1:0]   pend;
  logic [NUM_DOM-1:0]   pend_clr;
  logic [NUM_DOM-1:0]   enc_in;
  logic [GAP_W-1:0]     gap_cnt;
  logic [DOM_IDX_W-1:0] enc_idx;
  logic                 enc_vld;
  logic                 mode_ok;
  logic                 dom_hit;
  logic                 tmo_hit;

  assign mode_ok  = scan_mode & opcg_mode;
  assign pend_clr = pend & ~(NUM_DOM'(1) << cur_dom);
  assign dom_hit  = (state == ST_WAIT) && dom_done[cur_dom];

  // Encoder looks at whatever mask the next TRIG will be chosen from.
  always_comb begin
    enc_in = pend;
    case (state)
      ST_IDLE: enc_in = dom_mask;
      ST_WAIT: enc_in = pend_clr;
      default: enc_in = pend;
    endcase
  end

  rcg_opcg_pri_enc u_pri_enc (
    .req   (enc_in),
    .idx_c (enc_idx),
    .vld_c (enc_vld)
  );

`ifdef RCG_OPCG_SCHED_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt;

  assign tmo_hit = (state == ST_WAIT) && (tmo_cnt == TIMEOUT_MAX - TMO_W'(1));

  always_ff @(posedge clk_in) begin
    if (!grst_n) begin
      tmo_cnt <= '0;
      err     <= 1'b0;
    end else begin
      if (state == ST_TRIG) begin
        tmo_cnt <= '0;
      end else if (state == ST_WAIT) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
      if ((state == ST_IDLE) && start && mode_ok) begin
        err <= 1'b0;
      end else if (mode_ok && tmo_hit && !dom_hit) begin
        err <= 1'b1;
      end
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  // Triggers are issued on the edge that enters TRIG so they are visible in the TRIG cycle.
  always_ff @(posedge clk_in) begin
    if (!grst_n) begin
      state    <= ST_IDLE;
      pend     <= '0;
      gap_cnt  <= '0;
      dom_trig <= '0;
      cur_dom  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      dom_trig <= '0;
      done     <= 1'b0;
      if ((state != ST_IDLE) && !mode_ok) begin
        state <= ST_IDLE;
        pend  <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && mode_ok) begin
              pend <= dom_mask;
              busy <= 1'b1;
              if (enc_vld) begin
                state    <= ST_TRIG;
                dom_trig <= NUM_DOM'(1) << enc_idx;
                cur_dom  <= enc_idx;
              end else begin
                state <= ST_DONE;
                done  <= 1'b1;
              end
            end
          end
          ST_TRIG: state <= ST_WAIT;
          ST_WAIT: begin
            if (dom_hit || tmo_hit) begin
              pend <= pend_clr;
              if (!enc_vld) begin
                state <= ST_DONE;
                done  <= 1'b1;
              end else if (gap_cfg != '0) begin
                state   <= ST_GAP;
                gap_cnt <= gap_cfg;
              end else begin
                state    <= ST_TRIG;
                dom_trig <= NUM_DOM'(1) << enc_idx;
                cur_dom  <= enc_idx;
              end
            end
          end
          ST_GAP: begin
            gap_cnt <= gap_cnt - GAP_W'(1);
            if (gap_cnt == GAP_W'(1)) begin
              state    <= ST_TRIG;
              dom_trig <= NUM_DOM'(1) << enc_idx;
              cur_dom  <= enc_idx;
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rcg_opcg_sched.sv
// Scoreboard bench for rcg_opcg_sched: trigger/done events are matched against queued expectations.
module tb_rcg_opcg_sched;

  logic       clk_in    = 1'b0;
  logic       grst_n    = 1'b0;
  logic       scan_mode = 1'b0;
  logic       opcg_mode = 1'b0;
  logic       start     = 1'b0;
  logic [3:0] dom_mask  = '0;
  logic [3:0] gap_cfg   = '0;
  logic [3:0] dom_done  = '0;
  logic [3:0] dom_trig;
  logic [1:0] cur_dom;
  logic       busy;
  logic       done;
  logic       err;

  typedef struct packed {
    logic [31:0] cyc;
    logic [3:0]  trig;
    logic [1:0]  cdom;
    logic        done;
  } evt_t;

  evt_t        exp_q[$];
  evt_t        mon_act;
  evt_t        mon_exp;
  int unsigned cyc    = 0;
  int          checks = 0;
  int          errors = 0;

  rcg_opcg_sched dut (
    .clk_in    (clk_in),
    .grst_n    (grst_n),
    .scan_mode (scan_mode),
    .opcg_mode (opcg_mode),
    .start     (start),
    .dom_mask  (dom_mask),
    .gap_cfg   (gap_cfg),
    .dom_done  (dom_done),
    .dom_trig  (dom_trig),
    .cur_dom   (cur_dom),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic expect_evt(int unsigned c, logic [3:0] t, logic [1:0] d, logic dn);
    exp_q.push_back('{32'(c), t, d, dn});
  endtask

  // Monitor: every trigger or done pulse must match the oldest expected event.
  always @(negedge clk_in) begin
    if ((dom_trig != '0) || done) begin
      mon_act = '{32'(cyc), dom_trig, cur_dom, done};
      if (exp_q.size() == 0) begin
        chk("unexpected_evt", 64'(mon_act), 64'(0));
      end else begin
        mon_exp = exp_q.pop_front();
        chk("evt{cyc,trig,dom,done}", 64'(mon_act), 64'(mon_exp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    repeat (3) tick();
    chk("rst_trig", dom_trig, 4'b0000);
    chk("rst_cur_dom", cur_dom, 2'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    grst_n = 1'b1; scan_mode = 1'b1; opcg_mode = 1'b1;

    // Full mask, no gap, dom_done 3 cycles after each trigger.
    tick(); n = cyc; start = 1'b1; dom_mask = 4'b1111; gap_cfg = 4'd0;
    expect_evt(n + 1,  4'b0001, 2'd0, 1'b0);
    expect_evt(n + 5,  4'b0010, 2'd1, 1'b0);
    expect_evt(n + 9,  4'b0100, 2'd2, 1'b0);
    expect_evt(n + 13, 4'b1000, 2'd3, 1'b0);
    expect_evt(n + 17, 4'b0000, 2'd3, 1'b1);
    for (int c = 1; c <= 18; c++) begin
      tick(); start = 1'b0; dom_done = '0;
      for (int k = 0; k < 4; k++) if (c == 4 + 4 * k) dom_done[k] = 1'b1;
      if (c == 2)  chk("s1_busy_wait", busy, 1'b1);
      if (c == 17) chk("s1_busy_at_done", busy, 1'b1);
      if (c == 18) chk("s1_busy_after_done", busy, 1'b0);
    end
    chk("s1_err", err, 1'b0);

    // Sparse mask with a 5-cycle gap.
    tick(); n = cyc; start = 1'b1; dom_mask = 4'b1010; gap_cfg = 4'd5;
    expect_evt(n + 1,  4'b0010, 2'd1, 1'b0);
    expect_evt(n + 10, 4'b1000, 2'd3, 1'b0);
    expect_evt(n + 14, 4'b0000, 2'd3, 1'b1);
    for (int c = 1; c <= 15; c++) begin
      tick(); start = 1'b0; dom_done = '0;
      if (c == 4)  dom_done = 4'b0010;
      if (c == 13) dom_done = 4'b1000;
      if (c == 7)  chk("s2_busy_gap", busy, 1'b1);
      if (c == 15) chk("s2_busy_after_done", busy, 1'b0);
    end

    // Empty mask: done next cycle, cur_dom holds its last value.
    tick(); n = cyc; start = 1'b1; dom_mask = 4'b0000; gap_cfg = 4'd0;
    expect_evt(n + 1, 4'b0000, 2'd3, 1'b1);
    tick(); start = 1'b0;
    chk("s3_busy_one", busy, 1'b1);
    tick();
    chk("s3_busy_after", busy, 1'b0);
    chk("s3_cur_dom_hold", cur_dom, 2'd3);

    // Abort while waiting on domain 2; start while busy must be ignored.
    tick(); n = cyc; start = 1'b1; dom_mask = 4'b0111;
    expect_evt(n + 1, 4'b0001, 2'd0, 1'b0);
    expect_evt(n + 5, 4'b0010, 2'd1, 1'b0);
    expect_evt(n + 9, 4'b0100, 2'd2, 1'b0);
    for (int c = 1; c <= 16; c++) begin
      tick(); start = 1'b0; dom_done = '0;
      if (c == 4)  dom_done = 4'b0001;
      if (c == 8)  dom_done = 4'b0010;
      if (c == 10) begin start = 1'b1; dom_mask = 4'b1111; end
      if (c == 11) begin opcg_mode = 1'b0; chk("s4_busy_pre_abort", busy, 1'b1); end
      if (c == 12) begin opcg_mode = 1'b1; chk("s4_busy_aborted", busy, 1'b0); end
      if (c == 13) dom_done = 4'b0100;
      if (c == 16) chk("s4_busy_idle", busy, 1'b0);
    end

    // Wrong-domain done and done during the TRIG cycle are both ignored.
    tick(); n = cyc; start = 1'b1; dom_mask = 4'b1001;
    expect_evt(n + 1, 4'b0001, 2'd0, 1'b0);
    expect_evt(n + 5, 4'b1000, 2'd3, 1'b0);
    expect_evt(n + 8, 4'b0000, 2'd3, 1'b1);
    for (int c = 1; c <= 9; c++) begin
      tick(); start = 1'b0; dom_done = '0;
      if (c == 1) dom_done = 4'b0001;
      if (c == 2) dom_done = 4'b1000;
      if (c == 3) begin chk("s5_busy_wait", busy, 1'b1); chk("s5_cur_dom", cur_dom, 2'd0); end
      if (c == 4) dom_done = 4'b0001;
      if (c == 7) dom_done = 4'b1000;
      if (c == 9) chk("s5_busy_after", busy, 1'b0);
    end

    // Mode gating: start rejected unless both scan_mode and opcg_mode are high.
    tick(); scan_mode = 1'b0; start = 1'b1; dom_mask = 4'b0001;
    tick(); start = 1'b0; scan_mode = 1'b1;
    chk("s6_scan_gate", busy, 1'b0);
    opcg_mode = 1'b0; start = 1'b1;
    tick(); start = 1'b0; opcg_mode = 1'b1;
    chk("s6_opcg_gate", busy, 1'b0);

    // Reset mid-sequence.
    tick(); n = cyc; start = 1'b1; dom_mask = 4'b0010;
    expect_evt(n + 1, 4'b0010, 2'd1, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      tick(); start = 1'b0; dom_done = '0;
      if (c == 2) grst_n = 1'b0;
      if (c == 3) begin
        grst_n = 1'b1;
        chk("s7_busy_rst", busy, 1'b0);
        chk("s7_cur_dom_rst", cur_dom, 2'd0);
      end
      if (c == 4) dom_done = 4'b0010;
      if (c == 5) chk("s7_busy_idle", busy, 1'b0);
    end

`ifdef RCG_OPCG_SCHED_TIMEOUT_EN
    // Timeout: 255 WAIT cycles with no dom_done, then err and done.
    tick(); n = cyc; start = 1'b1; dom_mask = 4'b0001;
    expect_evt(n + 1,   4'b0001, 2'd0, 1'b0);
    expect_evt(n + 257, 4'b0000, 2'd0, 1'b1);
    for (int c = 1; c <= 258; c++) begin
      tick(); start = 1'b0;
      if (c == 256) chk("s8_err_before", err, 1'b0);
      if (c == 257) chk("s8_err_set", err, 1'b1);
      if (c == 258) begin start = 1'b1; dom_mask = 4'b0000; expect_evt(n + 259, 4'b0000, 2'd0, 1'b1); end
    end
    tick(); start = 1'b0;
    chk("s8_err_cleared", err, 1'b0);
`else
    chk("s8_err_tied", err, 1'b0);
`endif

    repeat (3) tick();
    chk("queue_drain", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
